// File: rtl/generador_sincronia_vga_if.sv
// Purpose: bundle of the VGA timing outputs (pixel tick, pixel/line counters,
//          syncs, video window and frame marker) shared by the generator and
//          its consumers.
// Signals:
//   p_tick      one-cycle pixel tick
//   Qh, Qv      horizontal pixel / vertical line counters
//   hsync/vsync active-low sync pulses
//   video_on    high inside the visible area
//   frame_start one-cycle pulse when the counters wrap to (0,0)
// Modports: master (generator drives), slave (consumers read).
interface generador_sincronia_vga_if;
  localparam int unsigned CNT_W = 10;

  logic             p_tick;
  logic [CNT_W-1:0] Qh;
  logic [CNT_W-1:0] Qv;
  logic             hsync;
  logic             vsync;
  logic             video_on;
  logic             frame_start;

  modport master (
    output p_tick, Qh, Qv, hsync, vsync, video_on, frame_start
  );

  modport slave (
    input p_tick, Qh, Qv, hsync, vsync, video_on, frame_start
  );
endinterface

// File: rtl/generador_sincronia_vga.sv
// Purpose: VGA timing generator. Divides reloj into a pixel tick, runs the
//          horizontal/vertical counters and produces registered syncs,
//          video_on and frame_start that are always consistent with Qh/Qv.
// Ports:
//   reloj   system clock
//   resetM  asynchronous active-low reset
//   vga     timing outputs (master modport of generador_sincronia_vga_if)
module generador_sincronia_vga #(
  parameter int unsigned DIV       = 4,
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic                             reloj,
  input  logic                             resetM,
  generador_sincronia_vga_if.master        vga
);

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned DIV_W   = 4;
  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_DISPLAY + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_DISPLAY + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [DIV_W-1:0] div_cnt;
  logic             div_wrap_c;
  logic             line_end_c;
  logic             frame_end_c;
  logic [CNT_W-1:0] qh_nxt_c;
  logic [CNT_W-1:0] qv_nxt_c;
  logic             hsync_nxt_c;
  logic             vsync_nxt_c;
  logic             video_nxt_c;

  // Next counter values and the sync/video decode of those values, so the
  // registered outputs change on the same edge as the counters.
  always_comb begin
    div_wrap_c  = (div_cnt == DIV_LAST);
    line_end_c  = (vga.Qh == H_LAST);
    frame_end_c = line_end_c && (vga.Qv == V_LAST);
    qh_nxt_c    = line_end_c ? '0 : vga.Qh + CNT_W'(1);
    qv_nxt_c    = vga.Qv;
    if (line_end_c) begin
      qv_nxt_c = (vga.Qv == V_LAST) ? '0 : vga.Qv + CNT_W'(1);
    end
    hsync_nxt_c = !((qh_nxt_c >= HS_START) && (qh_nxt_c < HS_END));
    vsync_nxt_c = !((qv_nxt_c >= VS_START) && (qv_nxt_c < VS_END));
    video_nxt_c = (qh_nxt_c < H_VIS) && (qv_nxt_c < V_VIS);
  end

  // Divider, counters and registered timing outputs.
  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      div_cnt         <= '0;
      vga.p_tick      <= 1'b0;
      vga.Qh          <= '0;
      vga.Qv          <= '0;
      vga.hsync       <= 1'b1;
      vga.vsync       <= 1'b1;
      vga.video_on    <= 1'b0;
      vga.frame_start <= 1'b0;
    end else begin
      div_cnt         <= div_wrap_c ? '0 : div_cnt + DIV_W'(1);
      vga.p_tick      <= div_wrap_c;
      vga.frame_start <= div_wrap_c && frame_end_c;
      if (div_wrap_c) begin
        vga.Qh       <= qh_nxt_c;
        vga.Qv       <= qv_nxt_c;
        vga.hsync    <= hsync_nxt_c;
        vga.vsync    <= vsync_nxt_c;
        vga.video_on <= video_nxt_c;
      end
    end
  end

endmodule

// File: tb/tb_generador_sincronia_vga.sv
// Purpose: directed self-checking bench for generador_sincronia_vga.
// A default-timing instance covers the divider, hsync window, line wrap and
// asynchronous reset; a shrunken instance (DIV=2, 16x10 total) covers the
// frame wrap, vsync window, frame period and video_on boundaries.
module tb_generador_sincronia_vga;

  logic        reloj = 1'b0;
  logic        resetM;
  int unsigned n_vec;
  int unsigned n_err;

  generador_sincronia_vga_if vif ();
  generador_sincronia_vga_if sif ();

  generador_sincronia_vga dut (
    .reloj  (reloj),
    .resetM (resetM),
    .vga    (vif.master)
  );

  // Small timing: H 8+2+3+3=16 (hsync Qh 10..12), V 6+1+2+1=10 (vsync Qv 7..8)
  generador_sincronia_vga #(
    .DIV(2), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) dut_s (
    .reloj  (reloj),
    .resetM (resetM),
    .vga    (sif.master)
  );

  always #5 reloj = ~reloj;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge reloj);
    #1;
  endtask

  initial begin
    int unsigned lowcnt;
    int unsigned cyc;
    int unsigned vs_low;
    int unsigned vs_bad;
    logic        found;
    logic        v_7_5;
    logic        v_8_5;
    logic        v_0_6;

    n_vec  = 0;
    n_err  = 0;
    resetM = 1'b0;

    // Reset values
    repeat (10) step();
    check("rst_p_tick",      32'(vif.p_tick), 32'd0);
    check("rst_qh",          32'(vif.Qh), 32'd0);
    check("rst_qv",          32'(vif.Qv), 32'd0);
    check("rst_hsync",       32'(vif.hsync), 32'd1);
    check("rst_vsync",       32'(vif.vsync), 32'd1);
    check("rst_video_on",    32'(vif.video_on), 32'd0);
    check("rst_frame_start", 32'(vif.frame_start), 32'd0);

    // Divider: first tick on the DIV-th edge after release
    resetM = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      check("div_p_tick",   32'(vif.p_tick), 32'(k % 4 == 0));
      check("div_p_tick_s", 32'(sif.p_tick), 32'(k % 2 == 0));
      if (k == 3) begin
        check("pre_tick_qh",    32'(vif.Qh), 32'd0);
        check("pre_tick_video", 32'(vif.video_on), 32'd0);
      end
      if (k == 4) begin
        check("first_tick_qh",    32'(vif.Qh), 32'd1);
        check("first_tick_qv",    32'(vif.Qv), 32'd0);
        check("first_tick_video", 32'(vif.video_on), 32'd1);
        check("first_tick_fs",    32'(vif.frame_start), 32'd0);
      end
      if (k == 5) check("hold_qh", 32'(vif.Qh), 32'd1);
    end

    // Hsync window
    found = 1'b0;
    for (int i = 0; i < 5000 && !found; i++) begin
      step();
      if (vif.Qh == 10'd655) found = 1'b1;
    end
    check("hs_reach_655", 32'(found), 32'd1);
    check("hs_high_655",  32'(vif.hsync), 32'd1);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      step();
      if (vif.Qh != 10'd655) found = 1'b1;
    end
    check("hs_fall_qh", 32'(vif.Qh), 32'd656);
    check("hs_fall",    32'(vif.hsync), 32'd0);
    lowcnt = 0;
    for (int i = 0; i < 1000 && vif.hsync == 1'b0; i++) begin
      lowcnt++;
      step();
    end
    check("hs_low_cycles", lowcnt, 32'd384);
    check("hs_rise_qh",    32'(vif.Qh), 32'd752);

    // Line wrap at (799,9)
    found = 1'b0;
    for (int i = 0; i < 40000 && !found; i++) begin
      step();
      if (vif.Qh == 10'd799 && vif.Qv == 10'd9) found = 1'b1;
    end
    check("lw_reach",  32'(found), 32'd1);
    check("lw_video0", 32'(vif.video_on), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      step();
      if (vif.Qh != 10'd799) found = 1'b1;
    end
    check("lw_qh",     32'(vif.Qh), 32'd0);
    check("lw_qv",     32'(vif.Qv), 32'd10);
    check("lw_video1", 32'(vif.video_on), 32'd1);
    step();
    check("lw_hold_qh", 32'(vif.Qh), 32'd0);

    // Frame wrap on the small instance
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      step();
      if (sif.Qh == 10'd15 && sif.Qv == 10'd9) found = 1'b1;
    end
    check("fw_reach",  32'(found), 32'd1);
    check("fw_fs_pre", 32'(sif.frame_start), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      step();
      if (sif.Qh != 10'd15) found = 1'b1;
    end
    check("fw_qh",     32'(sif.Qh), 32'd0);
    check("fw_qv",     32'(sif.Qv), 32'd0);
    check("fw_fs",     32'(sif.frame_start), 32'd1);
    check("vid_0_0",   32'(sif.video_on), 32'd1);
    step();
    check("fw_fs_one_cycle", 32'(sif.frame_start), 32'd0);

    // One full small frame: period, vsync window, video_on corners
    cyc    = 1;
    vs_low = 0;
    vs_bad = 0;
    v_7_5  = 1'bx;
    v_8_5  = 1'bx;
    v_0_6  = 1'bx;
    found  = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      step();
      cyc++;
      if (sif.frame_start) begin
        found = 1'b1;
      end else begin
        if (!sif.vsync) vs_low++;
        if ((!sif.vsync) != (sif.Qv == 10'd7 || sif.Qv == 10'd8)) vs_bad++;
        if (sif.Qh == 10'd7 && sif.Qv == 10'd5) v_7_5 = sif.video_on;
        if (sif.Qh == 10'd8 && sif.Qv == 10'd5) v_8_5 = sif.video_on;
        if (sif.Qh == 10'd0 && sif.Qv == 10'd6) v_0_6 = sif.video_on;
      end
    end
    check("frame_period",  cyc, 32'd320);
    check("vs_low_cycles", vs_low, 32'd64);
    check("vs_window_bad", vs_bad, 32'd0);
    check("vid_7_5",       32'(v_7_5), 32'd1);
    check("vid_8_5",       32'(v_8_5), 32'd0);
    check("vid_0_6",       32'(v_0_6), 32'd0);

    // Asynchronous mid-line reset on the default instance
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      step();
      if (vif.Qh == 10'd300) found = 1'b1;
    end
    check("ar_reach", 32'(found), 32'd1);
    #2 resetM = 1'b0;
    #1;
    check("ar_qh",     32'(vif.Qh), 32'd0);
    check("ar_qv",     32'(vif.Qv), 32'd0);
    check("ar_p_tick", 32'(vif.p_tick), 32'd0);
    check("ar_hsync",  32'(vif.hsync), 32'd1);
    check("ar_vsync",  32'(vif.vsync), 32'd1);
    check("ar_video",  32'(vif.video_on), 32'd0);
    check("ar_fs",     32'(vif.frame_start), 32'd0);
    #2 resetM = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      check("ar_div_p_tick", 32'(vif.p_tick), 32'(k == 4));
      if (k == 3) check("ar_pre_qh", 32'(vif.Qh), 32'd0);
    end
    check("ar_restart_qh", 32'(vif.Qh), 32'd1);
    check("ar_restart_qv", 32'(vif.Qv), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
